// File: rtl/lu_arbiter.sv
// ---------------------------------------------------------------------------
// LuArbiter: four-requester round-robin front end for one shared logic unit.
//
// A request is accepted in IDLE, its operands and opcode are latched and
// presented to the logic unit, the arbiter waits for the unit to finish, and
// the result is handed back to the requester with a one-cycle done pulse.
// Grant priority rotates so the requester after the last one served is
// searched first.
//
// Parameters
//   WIDTH      operand / result width (default 8)
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester request, held until that requester sees done
//   a_flat     operand A, requester i in [i*WIDTH +: WIDTH]
//   b_flat     operand B, same slicing
//   op_flat    2-bit opcode per requester in [i*2 +: 2]
//              (00 AND, 01 OR, 10 XOR, 11 NOT A)
//   gnt        one-hot accept pulse, high during the ISSUE cycle
//   done       one-hot completion pulse, high during the RESP cycle
//   result     result of the last completed operation, held until next done
//   busy       high whenever the FSM is not in IDLE
//   err        timeout flag, pulses together with done
//   lu_start   one-cycle start strobe to the logic unit (ISSUE cycle)
//   lu_a/lu_b  latched operands to the logic unit
//   lu_op      latched opcode to the logic unit
//   lu_done    logic unit completion, only looked at in WAIT
//   lu_result  logic unit result, captured when lu_done is seen in WAIT
//
// Build option
//   LU_ARBITER_TIMEOUT_EN  when defined, an 8-bit WAIT counter aborts an
//                          operation that never completes: done is pulsed
//                          with an all-ones result and err set. Without it
//                          err is tied low and WAIT lasts until lu_done.
// ---------------------------------------------------------------------------
module lu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] a_flat,
    input  logic [4*WIDTH-1:0] b_flat,
    input  logic [7:0]         op_flat,
    output logic [3:0]         gnt,
    output logic [3:0]         done,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               err,
    output logic               lu_start,
    output logic [WIDTH-1:0]   lu_a,
    output logic [WIDTH-1:0]   lu_b,
    output logic [1:0]         lu_op,
    input  logic               lu_done,
    input  logic [WIDTH-1:0]   lu_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [3:0]         done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               lu_start_q, lu_start_d;
    logic [WIDTH-1:0]   lu_a_q, lu_a_d;
    logic [WIDTH-1:0]   lu_b_q, lu_b_d;
    logic [1:0]         lu_op_q, lu_op_d;
`ifdef LU_ARBITER_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [1:0]         cand;

    // Round-robin search starting at rr_ptr. The loop runs from the farthest
    // offset down to offset 0 so the nearest set bit is the last one written.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        cand       = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr_q + 2'(k);
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic. Every output is a flop, so the value
    // chosen on a transition is what appears during the state being entered:
    // gnt and lu_start during ISSUE, done/result/err during RESP.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        gnt_d      = 4'b0000;
        done_d     = 4'b0000;
        result_d   = result_q;
        lu_start_d = 1'b0;
        lu_a_d     = lu_a_q;
        lu_b_d     = lu_b_q;
        lu_op_d    = lu_op_q;
`ifdef LU_ARBITER_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d      = pick_idx;
                    lu_a_d     = a_flat[int'(pick_idx)*WIDTH +: WIDTH];
                    lu_b_d     = b_flat[int'(pick_idx)*WIDTH +: WIDTH];
                    lu_op_d    = op_flat[int'(pick_idx)*2 +: 2];
                    gnt_d      = 4'b0001 << pick_idx;
                    lu_start_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
`ifdef LU_ARBITER_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                // A real completion takes priority over a timeout that
                // would expire on the same edge.
                if (lu_done) begin
                    result_d = lu_result;
                    done_d   = 4'b0001 << idx_q;
                    state_d  = RESP;
                end else begin
`ifdef LU_ARBITER_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'hFF) begin
                        result_d = '1;
                        done_d   = 4'b0001 << idx_q;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
`endif
                end
            end
            RESP: begin
                rr_ptr_d = idx_q + 2'd1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            idx_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            done_q     <= 4'b0000;
            result_q   <= '0;
            busy_q     <= 1'b0;
            lu_start_q <= 1'b0;
            lu_a_q     <= '0;
            lu_b_q     <= '0;
            lu_op_q    <= 2'd0;
`ifdef LU_ARBITER_TIMEOUT_EN
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            lu_start_q <= lu_start_d;
            lu_a_q     <= lu_a_d;
            lu_b_q     <= lu_b_d;
            lu_op_q    <= lu_op_d;
`ifdef LU_ARBITER_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign result   = result_q;
    assign busy     = busy_q;
    assign lu_start = lu_start_q;
    assign lu_a     = lu_a_q;
    assign lu_b     = lu_b_q;
    assign lu_op    = lu_op_q;
`ifdef LU_ARBITER_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_lu_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for lu_arbiter (WIDTH = 8).
// A small responder stands in for the shared logic unit: it answers each
// lu_start after a programmable number of cycles and can also inject a stray
// lu_done. Expected values below are worked out by hand.
// ---------------------------------------------------------------------------
module tb_lu_arbiter;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             resetN;
   logic [3:0]       req;
   logic [4*WIDTH-1:0] aFlat;
   logic [4*WIDTH-1:0] bFlat;
   logic [7:0]       opFlat;
   logic [3:0]       gnt;
   logic [3:0]       done;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             err;
   logic             luStart;
   logic [WIDTH-1:0] luA;
   logic [WIDTH-1:0] luB;
   logic [1:0]       luOp;
   logic             luDone = 1'b0;
   logic [WIDTH-1:0] luResult = '0;

   int checks = 0;
   int errors = 0;

   int luDelay = 0;
   bit luAuto = 1'b1;
   bit luKick = 1'b0;
   bit pending = 1'b0;
   int pendCnt = 0;

   lu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset_n   (resetN),
      .req       (req),
      .a_flat    (aFlat),
      .b_flat    (bFlat),
      .op_flat   (opFlat),
      .gnt       (gnt),
      .done      (done),
      .result    (result),
      .busy      (busy),
      .err       (err),
      .lu_start  (luStart),
      .lu_a      (luA),
      .lu_b      (luB),
      .lu_op     (luOp),
      .lu_done   (luDone),
      .lu_result (luResult)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Behaviour of the external logic unit itself
   function automatic logic [7:0] luModel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~a;
      endcase
   endfunction

   // Logic unit responder: sees lu_start just after an edge and raises
   // lu_done luDelay cycles after the following edge, for one cycle
   always @(posedge clk) begin
      #1;
      luDone = 1'b0;
      if (luKick) begin
         luDone   = 1'b1;
         luResult = 8'h5A;
         luKick   = 1'b0;
      end
      if (pending) begin
         if (pendCnt == 0) begin
            luDone   = 1'b1;
            luResult = luModel(luA, luB, luOp);
            pending  = 1'b0;
         end else begin
            pendCnt--;
         end
      end
      if (luStart && luAuto) begin
         pending = 1'b1;
         pendCnt = luDelay;
      end
   end

   // Hard stop in case something stalls the main sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to 2 time units after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r);
      req = r;
   endtask

   task automatic setOperands(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
      aFlat[i*WIDTH +: WIDTH] = a;
      bFlat[i*WIDTH +: WIDTH] = b;
      opFlat[i*2 +: 2]        = op;
   endtask

   // Waits for a grant, then for done; checks grant, done, result, err and
   // the number of cycles from the grant cycle to the done cycle
   task automatic expectTransaction(input string tag, input logic [3:0] expGnt,
                                    input logic [7:0] expResult, input logic expErr,
                                    input bit dropReq, input int expLat);
      int n = 0;
      while (gnt == 4'b0000 && n < 400) begin
         tick();
         n++;
      end
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'(expGnt));
      if (dropReq) applyStimulus(4'b0000);
      n = 0;
      while (done == 4'b0000 && n < 400) begin
         tick();
         n++;
      end
      checkOutput({tag, "_done"}, 32'(done), 32'(expGnt));
      checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
      checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
      checkOutput({tag, "_lat"}, n, expLat);
   endtask

   logic [7:0] rotRes [4];
   bit sawActivity;

   initial begin
      // Operation table for the rotation phase: A=3C, B=0F
      rotRes[0] = 8'h0C;   // AND
      rotRes[1] = 8'h3F;   // OR
      rotRes[2] = 8'h33;   // XOR
      rotRes[3] = 8'hC3;   // NOT A

      resetN = 1'b0;
      req    = 4'b0000;
      aFlat  = '0;
      bFlat  = '0;
      opFlat = '0;
      repeat (3) tick();

      // Reset state
      checkOutput("rst_gnt", 32'(gnt), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_result", 32'(result), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_err", 32'(err), 0);
      checkOutput("rst_luStart", 32'(luStart), 0);
      checkOutput("rst_luA", 32'(luA), 0);
      checkOutput("rst_luOp", 32'(luOp), 0);
      resetN = 1'b1;
      tick();

      // Single request from requester 0: 0F OR F0 = FF
      setOperands(0, 8'h0F, 8'hF0, 2'b01);
      applyStimulus(4'b0001);
      tick();
      checkOutput("t1_gnt", 32'(gnt), 32'h1);
      checkOutput("t1_luStart", 32'(luStart), 1);
      checkOutput("t1_luA", 32'(luA), 32'h0F);
      checkOutput("t1_luB", 32'(luB), 32'hF0);
      checkOutput("t1_luOp", 32'(luOp), 1);
      checkOutput("t1_busy", 32'(busy), 1);
      tick();
      checkOutput("t1_waitDone", 32'(done), 0);
      checkOutput("t1_waitStart", 32'(luStart), 0);
      tick();
      checkOutput("t1_done", 32'(done), 32'h1);
      checkOutput("t1_result", 32'(result), 32'hFF);
      checkOutput("t1_respBusy", 32'(busy), 1);
      applyStimulus(4'b0000);
      tick();
      checkOutput("t1_doneClr", 32'(done), 0);
      checkOutput("t1_idleBusy", 32'(busy), 0);
      checkOutput("t1_resultHeld", 32'(result), 32'hFF);

      for (int i = 0; i < 4; i++) setOperands(i, 8'h3C, 8'h0F, 2'(i));

      // Pointer is 1: serve requester 2 so the pointer lands on 3, then 1001
      // arriving in RESP must go to 3 first and wrap to 0
      applyStimulus(4'b0100);
      expectTransaction("ptr3", 4'b0100, 8'h33, 1'b0, 1'b0, 2);
      applyStimulus(4'b1001);
      expectTransaction("wrap3", 4'b1000, 8'hC3, 1'b0, 1'b0, 2);
      applyStimulus(4'b0001);
      expectTransaction("wrap0", 4'b0001, 8'h0C, 1'b0, 1'b0, 2);
      applyStimulus(4'b0000);
      tick();

      // Request withdrawn right after the grant still completes
      applyStimulus(4'b0010);
      expectTransaction("drop1", 4'b0010, 8'h3F, 1'b0, 1'b1, 2);
      tick();

      // Stray lu_done while idle is ignored
      luKick = 1'b1;
      repeat (3) tick();
      checkOutput("stray_busy", 32'(busy), 0);
      checkOutput("stray_result", 32'(result), 32'h3F);

      // Reset while waiting on the unit; its late lu_done must be ignored
      luDelay = 3;
      applyStimulus(4'b0100);
      tick();
      checkOutput("rw_gnt", 32'(gnt), 32'h4);
      tick();
      tick();
      resetN = 1'b0;
      applyStimulus(4'b0000);
      #1;
      checkOutput("rw_busy", 32'(busy), 0);
      checkOutput("rw_done", 32'(done), 0);
      checkOutput("rw_result", 32'(result), 0);
      checkOutput("rw_luA", 32'(luA), 0);
      checkOutput("rw_luOp", 32'(luOp), 0);
      luDelay = 0;
      tick();
      resetN = 1'b1;
      sawActivity = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done != 4'b0000 || busy) sawActivity = 1'b1;
      end
      checkOutput("rw_noDone", 32'(sawActivity), 0);

      // All four requesting: grants rotate 0,1,2,3,0 starting fresh after reset
      applyStimulus(4'b1111);
      for (int k = 0; k < 5; k++) begin
         expectTransaction($sformatf("rot%0d", k), 4'(1 << (k % 4)), rotRes[k % 4], 1'b0, 1'b0, 2);
      end
      applyStimulus(4'b0000);
      tick();

`ifdef LU_ARBITER_TIMEOUT_EN
      // Unit never answers: timeout 256 cycles after lu_start
      luAuto = 1'b0;
      applyStimulus(4'b0001);
      expectTransaction("tmo", 4'b0001, 8'hFF, 1'b1, 1'b0, 256);
      applyStimulus(4'b0000);
      tick();
      checkOutput("tmo_errPulse", 32'(err), 0);
      luAuto = 1'b1;
      // lu_done on the very cycle the count would expire wins
      luDelay = 254;
      applyStimulus(4'b0001);
      expectTransaction("tmoRace", 4'b0001, 8'h0C, 1'b0, 1'b0, 256);
      applyStimulus(4'b0000);
      luDelay = 0;
      tick();
`else
      // Without the timeout, a slow unit is simply waited for
      luDelay = 300;
      applyStimulus(4'b0001);
      expectTransaction("slow", 4'b0001, 8'h0C, 1'b0, 1'b0, 302);
      applyStimulus(4'b0000);
      luDelay = 0;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lu_arbiter.md
LU_ARBITER -- requirements
Module: lu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester request; held high by requester until its done pulse.
REQ-005 a_flat  input  4*WIDTH  operand A per requester; requester i uses bits [i*WIDTH +: WIDTH].
REQ-006 b_flat  input  4*WIDTH  operand B per requester, same slicing.
REQ-007 op_flat  input  8  2-bit opcode per requester, slice [i*2 +: 2]: 00 AND, 01 OR, 10 XOR, 11 NOT A.
REQ-008 gnt  output  4  one-hot, one-cycle pulse marking the accepted requester.
REQ-009 done  output  4  one-hot, one-cycle pulse marking completion for the granted requester.
REQ-010 result  output  WIDTH  operation result; valid only in the done cycle, held until next done.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  one-cycle timeout pulse coincident with done.
REQ-013 lu_start  output  1  one-cycle start pulse to the shared logic unit.
REQ-014 lu_a, lu_b  output  WIDTH  latched operands to the logic unit; stable from ISSUE until return to IDLE.
REQ-015 lu_op  output  2  latched opcode to the logic unit.
REQ-016 lu_done  input  1  logic unit completion; sampled only in WAIT.
REQ-017 lu_result  input  WIDTH  logic unit result; captured in the cycle lu_done is sampled high.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any req bit is set, select the first set bit at or after rr_ptr, searching upward modulo 4; latch its operands and opcode into lu_a/lu_b/lu_op; pulse gnt[idx]; go to ISSUE.
REQ-020 ISSUE: pulse lu_start for exactly one cycle; go to WAIT.
REQ-021 WAIT: on lu_done=1, capture lu_result; go to RESP. Otherwise remain in WAIT.
REQ-022 RESP: drive result and pulse done[idx]; set rr_ptr=(idx+1) mod 4, wrapping 3->0; go to IDLE.
REQ-023 Minimum request-to-done latency: 4 cycles when lu_done arrives in the first WAIT cycle.
REQ-024 Deassertion of req after gnt SHALL NOT abort the operation; done is still pulsed.
REQ-025 No new grant SHALL be issued while busy; a request arriving in RESP is considered in the following IDLE cycle.
REQ-026 lu_done outside WAIT SHALL be ignored.
REQ-027 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-028 reset_n low, at any time including mid-operation, SHALL immediately force IDLE and rr_ptr=0, and clear gnt, done, result, busy, err, lu_start, lu_a, lu_b, lu_op and the timeout counter.
REQ-029 An operation interrupted by reset SHALL NOT produce a done pulse; a late lu_done after reset is ignored.

Configuration
REQ-030 Macro LU_ARBITER_TIMEOUT_EN: when defined, an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. If it reaches 255 without lu_done, the FSM goes to RESP with result forced to all ones and err pulsed alongside done.
REQ-031 If lu_done and the 255th count occur in the same cycle, lu_done SHALL win: normal result and err=0.
REQ-032 When LU_ARBITER_TIMEOUT_EN is undefined, no counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL last until lu_done.

Verification
REQ-033 req=0001, a0=0x0F, b0=0xF0, op0=01, lu_done one cycle after lu_start with 0xFF -> gnt=0001, then done=0001 with result=0xFF, 4 cycles after req.
REQ-034 req=1111 held continuously -> grant order 0,1,2,3,0, with each done one-hot and matching its gnt.
REQ-035 rr_ptr=3, req=1001 -> grant to 3, then grant to 0 (wrap-around).
REQ-036 reset_n pulsed low in WAIT, then lu_done asserted -> no done pulse; all outputs 0; next grant goes to requester 0.
REQ-037 Macro defined, lu_done never asserted -> done plus err exactly 256 cycles after lu_start, result=0xFF; lu_done on count 255 -> err=0.
